// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch
//  Brief    : Instruction-fetch front end. Owns the architectural PC and
//             issues single-beat Wishbone classic reads. Each fetched
//             instruction is presented with its PC to IF/ID under a
//             valid/stall handshake. Redirects override PC+4 advance, and
//             wrong-path fetches are squashed.
//  Option   : PC_FETCH_ALIGN_CHECK_EN - when defined, a misaligned redirect
//             target traps into a sticky FAULT state instead of being
//             silently aligned.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
   parameter int                      ADDR_WIDTH = 32,
   parameter int                      DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   PC_ADDR    = 32'h8000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   redirect_i,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
   input  logic                   stall_i,
   output logic                   imem_cyc_o,
   output logic                   imem_stb_o,
   output logic [ADDR_WIDTH-1:0]  imem_adr_o,
   input  logic                   imem_ack_i,
   input  logic [DATA_WIDTH-1:0]  imem_dat_i,
   output logic                   inst_valid_o,
   output logic [DATA_WIDTH-1:0]  inst_o,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   output logic                   fetch_fault_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] c_PC_STEP    = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'(3);

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic [DATA_WIDTH-1:0]   r_inst;
   logic                    r_kill;       // outstanding request is wrong-path
   logic [ADDR_WIDTH-1:0]   r_pend_pc;    // redirect target waiting for the ack
   logic                    r_fault_pend; // pending redirect target was misaligned

   logic [ADDR_WIDTH-1:0]   w_redir_tgt;
   logic                    w_redir_bad;

`ifdef PC_FETCH_ALIGN_CHECK_EN
   // Misaligned targets are never loaded; they steer the FSM into FAULT.
   assign w_redir_tgt = redirect_pc_i;
   assign w_redir_bad = |(redirect_pc_i & c_ALIGN_MASK);
`else
   // Without the check, low target bits are simply cleared.
   assign w_redir_tgt = redirect_pc_i & ~c_ALIGN_MASK;
   assign w_redir_bad = 1'b0;
`endif

   // Fetch FSM: PC, held instruction and wrong-path squash bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_pc         <= PC_ADDR;
         r_inst       <= '0;
         r_kill       <= 1'b0;
         r_pend_pc    <= '0;
         r_fault_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Any late ack from a transaction cut short by reset lands here
               // and is ignored.
               r_state <= S_FETCH;
            end

            S_FETCH: begin
               if (redirect_i) begin
                  if (imem_ack_i) begin
                     // Data belongs to the old path; the ack closes it out.
                     r_kill       <= 1'b0;
                     r_fault_pend <= 1'b0;
                     if (w_redir_bad) begin
                        r_state <= S_FAULT;
                     end else begin
                        r_pc <= w_redir_tgt;
                     end
                  end else begin
                     // Bus request must stay stable until ack; remember the
                     // latest target (last redirect wins).
                     r_pend_pc    <= w_redir_tgt;
                     r_kill       <= 1'b1;
                     r_fault_pend <= w_redir_bad;
                  end
               end else if (imem_ack_i) begin
                  if (r_kill) begin
                     r_kill       <= 1'b0;
                     r_fault_pend <= 1'b0;
                     if (r_fault_pend) begin
                        r_state <= S_FAULT;
                     end else begin
                        r_pc <= r_pend_pc;
                     end
                  end else begin
                     r_inst  <= imem_dat_i;
                     r_state <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               if (redirect_i) begin
                  // Redirect beats stall; the held instruction is dropped.
                  if (w_redir_bad) begin
                     r_state <= S_FAULT;
                  end else begin
                     r_pc    <= w_redir_tgt;
                     r_state <= S_FETCH;
                  end
               end else if (!stall_i) begin
                  r_pc    <= r_pc + c_PC_STEP;
                  r_state <= S_FETCH;
               end
            end

            S_FAULT: begin
               r_state <= S_FAULT;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode registered state only; no input-to-output paths.
   assign imem_cyc_o   = (r_state == S_FETCH);
   assign imem_stb_o   = (r_state == S_FETCH);
   assign imem_adr_o   = r_pc;
   assign inst_valid_o = (r_state == S_HOLD);
   assign inst_o       = r_inst;
   assign pc_o         = r_pc;

`ifdef PC_FETCH_ALIGN_CHECK_EN
   assign fetch_fault_o = (r_state == S_FAULT);
`else
   assign fetch_fault_o = 1'b0;
`endif

endmodule
`default_nettype wire
